cam_pwdn_seq: RTL and testbench

- Orderly camera power-down sequencer; the counterpart of the power-up delay generator on the camera power path.
- On request it:
  - stops the CSI-2 stream,
  - waits for the lanes to settle in LP stop state (or times out),
  - holds the sensor in reset for a fixed time,
  - removes sensor power,
  - reports done after a power-off settle time.
- Sits between the system control logic, the CSI-2 receiver (for the idle indication) and the camera enable/reset pins.

---
 rtl/cam_pwr_pkg.sv | 28 ++
 rtl/cam_pwdn_seq_if.sv | 35 +++
 rtl/cam_idle_filter.sv | 37 +++
 rtl/cam_pwdn_seq.sv | 135 +++++++++++++
 tb/tb_cam_pwdn_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cam_pwr_pkg.sv
// Shared types and helpers for the camera power path sequencers.
// The us-to-ticks conversion is also used by the power-up delay block.
package cam_pwr_pkg;

    typedef enum logic [2:0] {
        StOn     = 3'd0,
        StDrain  = 3'd1,
        StRst    = 3'd2,
        StPwrOff = 3'd3,
        StOff    = 3'd4
    } pwr_state_e;

    // Evaluated at elaboration; 64-bit product avoids overflow at high clock rates.
    function automatic int unsigned us_to_ticks(input int unsigned us,
                                                input int unsigned clk_freq);
        longint unsigned ticks;
        ticks = (64'(us) * 64'(clk_freq)) / 64'd1_000_000;
        if (ticks < 64'd1) begin
            ticks = 64'd1;
        end
        return 32'(ticks);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_pwdn_seq_if.sv
// Control/status bundle between system logic, CSI-2 receiver and the power-down sequencer.
interface cam_pwdn_seq_if;

    logic pwdn_req_i;
    logic csi_lp_idle_i;
    logic stream_en_o;
    logic cam_rst_n_o;
    logic cam_pwr_en_o;
    logic busy_o;
    logic pwdn_done_o;
    logic timeout_o;

    modport slave (
        input  pwdn_req_i,
        input  csi_lp_idle_i,
        output stream_en_o,
        output cam_rst_n_o,
        output cam_pwr_en_o,
        output busy_o,
        output pwdn_done_o,
        output timeout_o
    );

    modport master (
        output pwdn_req_i,
        output csi_lp_idle_i,
        input  stream_en_o,
        input  cam_rst_n_o,
        input  cam_pwr_en_o,
        input  busy_o,
        input  pwdn_done_o,
        input  timeout_o
    );

endinterface

// File: rtl/cam_idle_filter.sv
// Run-length detector: stable_o flags the cycle on which idle_i completes a run of
// IDLE_STABLE consecutive high samples while enabled.
module cam_idle_filter #(
    parameter int unsigned IDLE_STABLE = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic idle_i,
    output logic stable_o
);

    localparam int unsigned RunW = $clog2(IDLE_STABLE + 1);
    localparam logic [RunW-1:0] RunLast = RunW'(IDLE_STABLE - 1);

    logic [RunW-1:0] r_run;
    logic [RunW-1:0] w_run_d;

    always_comb begin
        w_run_d = '0;
        if (en_i && idle_i) begin
            w_run_d = (r_run == RunLast) ? r_run : r_run + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run <= '0;
        end else begin
            r_run <= w_run_d;
        end
    end

    // Combinational so the sequencer can leave DRAIN on the very edge the run completes.
    assign stable_o = en_i && idle_i && (r_run == RunLast);

endmodule

// File: rtl/cam_pwdn_seq.sv
// Orderly camera power-down: stop stream, drain CSI-2 lanes, hold sensor reset,
// drop sensor power, then report done after a settle time.
module cam_pwdn_seq
    import cam_pwr_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 74_250_000,
    parameter int unsigned IDLE_STABLE     = 16,
    parameter int unsigned IDLE_TIMEOUT_US = 1000,
    parameter int unsigned RST_HOLD_US     = 10,
    parameter int unsigned PWR_OFF_US      = 100
) (
    input logic           clk_i,
    input logic           rst_n_i,
    cam_pwdn_seq_if.slave bus
);

    localparam int unsigned TimeoutTicks = us_to_ticks(IDLE_TIMEOUT_US, CLK_FREQ);
    localparam int unsigned HoldTicks    = us_to_ticks(RST_HOLD_US, CLK_FREQ);
    localparam int unsigned OffTicks     = us_to_ticks(PWR_OFF_US, CLK_FREQ);
    localparam int unsigned MaxTicks     = max_u(max_u(TimeoutTicks, HoldTicks),
                                                 max_u(OffTicks, IDLE_STABLE));
    localparam int unsigned CntW         = $clog2(MaxTicks + 1);

    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutTicks - 1);
    localparam logic [CntW-1:0] HoldLast    = CntW'(HoldTicks - 1);
    localparam logic [CntW-1:0] OffLast     = CntW'(OffTicks - 1);

    pwr_state_e      r_state;
    pwr_state_e      w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            w_timeout_hit;
    logic            w_stable_idle;

    logic r_stream_en, r_cam_rst_n, r_cam_pwr_en, r_busy, r_done, r_timeout;
    logic w_stream_en_d, w_cam_rst_n_d, w_cam_pwr_en_d, w_busy_d, w_done_d, w_timeout_d;

    cam_idle_filter #(
        .IDLE_STABLE (IDLE_STABLE)
    ) u_idle_filter (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (r_state == StDrain),
        .idle_i   (bus.csi_lp_idle_i),
        .stable_o (w_stable_idle)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= StOn;
            r_cnt        <= '0;
            r_stream_en  <= 1'b1;
            r_cam_rst_n  <= 1'b1;
            r_cam_pwr_en <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_stream_en  <= w_stream_en_d;
            r_cam_rst_n  <= w_cam_rst_n_d;
            r_cam_pwr_en <= w_cam_pwr_en_d;
            r_busy       <= w_busy_d;
            r_done       <= w_done_d;
            r_timeout    <= w_timeout_d;
        end
    end

    // Each timed phase counts 0..N-1 and leaves on the Nth edge, clearing the counter.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_timeout_hit = 1'b0;
        unique case (r_state)
            StOn: begin
                w_cnt_d = '0;
                if (bus.pwdn_req_i) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                w_cnt_d = r_cnt + 1'b1;
                if (w_stable_idle) begin
                    w_state_d = StRst;
                    w_cnt_d   = '0;
                end else if (r_cnt == TimeoutLast) begin
                    w_state_d     = StRst;
                    w_cnt_d       = '0;
                    w_timeout_hit = 1'b1;
                end
            end
            StRst: begin
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == HoldLast) begin
                    w_state_d = StPwrOff;
                    w_cnt_d   = '0;
                end
            end
            StPwrOff: begin
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == OffLast) begin
                    w_state_d = StOff;
                    w_cnt_d   = '0;
                end
            end
            StOff: begin
                w_cnt_d = '0;
            end
            default: begin
                w_state_d = StOn;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state, so every rail change lands on the transition edge.
    always_comb begin
        w_stream_en_d  = (w_state_d == StOn);
        w_cam_rst_n_d  = (w_state_d == StOn) || (w_state_d == StDrain);
        w_cam_pwr_en_d = w_cam_rst_n_d || (w_state_d == StRst);
        w_busy_d       = (w_state_d == StDrain) || (w_state_d == StRst) ||
                         (w_state_d == StPwrOff);
        w_done_d       = (w_state_d == StOff);
        w_timeout_d    = r_timeout || w_timeout_hit;
    end

    assign bus.stream_en_o  = r_stream_en;
    assign bus.cam_rst_n_o  = r_cam_rst_n;
    assign bus.cam_pwr_en_o = r_cam_pwr_en;
    assign bus.busy_o       = r_busy;
    assign bus.pwdn_done_o  = r_done;
    assign bus.timeout_o    = r_timeout;

endmodule

// File: tb/tb_cam_pwdn_seq.sv
// Directed bench for cam_pwdn_seq at 1 MHz (1 tick = 1 us).
// Output vector order: {stream_en, cam_rst_n, cam_pwr_en, busy, done, timeout}.
module tb_cam_pwdn_seq;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    cam_pwdn_seq_if bus ();

    cam_pwdn_seq #(
        .CLK_FREQ        (1_000_000),
        .IDLE_STABLE     (16),
        .IDLE_TIMEOUT_US (1000),
        .RST_HOLD_US     (10),
        .PWR_OFF_US      (100)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] outs();
        return {bus.stream_en_o, bus.cam_rst_n_o, bus.cam_pwr_en_o,
                bus.busy_o, bus.pwdn_done_o, bus.timeout_o};
    endfunction

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // cyc counts edges; inputs change and outputs are sampled 1 ns after an edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic do_reset(input string tag);
        bus.pwdn_req_i    = 1'b0;
        bus.csi_lp_idle_i = 1'b0;
        rst_n_i = 1'b0;
        #2;
        chk({tag, "_async_rst"}, outs(), 6'b111000);
        step(2);
        rst_n_i = 1'b1;
        step(1);
        cyc = 0;
    endtask

    // Request at cycle 10, idle from 20; a second request arrives during RST.
    task automatic run_nominal(input string tag, input bit hold_req);
        goto_cyc(10);
        bus.pwdn_req_i = 1'b1;
        chk({tag, "_c10"}, outs(), 6'b111000);
        step(1);
        chk({tag, "_c11_stream_off"}, outs(), 6'b011100);
        if (!hold_req) bus.pwdn_req_i = 1'b0;
        goto_cyc(20);
        bus.csi_lp_idle_i = 1'b1;
        goto_cyc(35);
        chk({tag, "_c35"}, outs(), 6'b011100);
        step(1);
        chk({tag, "_c36_rst_low"}, outs(), 6'b001100);
        goto_cyc(38);
        if (hold_req) bus.pwdn_req_i = 1'b0;
        goto_cyc(40);
        bus.pwdn_req_i = 1'b1;
        step(1);
        if (!hold_req) bus.pwdn_req_i = 1'b0;
        goto_cyc(45);
        chk({tag, "_c45"}, outs(), 6'b001100);
        step(1);
        chk({tag, "_c46_pwr_off"}, outs(), 6'b000100);
        goto_cyc(145);
        chk({tag, "_c145"}, outs(), 6'b000100);
        step(1);
        chk({tag, "_c146_done"}, outs(), 6'b000010);
        goto_cyc(400);
        chk({tag, "_c400_terminal"}, outs(), 6'b000010);
        bus.pwdn_req_i    = 1'b0;
        bus.csi_lp_idle_i = 1'b0;
    endtask

    initial begin
        #1;

        // 1: no request for 5000 cycles
        do_reset("s1");
        for (int i = 1; i <= 5; i++) begin
            goto_cyc(i * 1000);
            chk("s1_idle_on", outs(), 6'b111000);
        end

        // 2: nominal pulse request
        do_reset("s2");
        run_nominal("s2", 1'b0);

        // 3: idle never asserted -> timeout
        do_reset("s3");
        goto_cyc(10);
        bus.pwdn_req_i = 1'b1;
        step(1);
        bus.pwdn_req_i = 1'b0;
        goto_cyc(1010);
        chk("s3_c1010", outs(), 6'b011100);
        step(1);
        chk("s3_c1011_timeout", outs(), 6'b001101);
        goto_cyc(1021);
        chk("s3_c1021_pwr_off", outs(), 6'b000101);
        goto_cyc(1121);
        chk("s3_c1121_done", outs(), 6'b000011);

        // 4a: runs of 15 with 1-cycle gaps never qualify
        do_reset("s4a");
        goto_cyc(10);
        bus.pwdn_req_i = 1'b1;
        step(1);
        bus.pwdn_req_i = 1'b0;
        while (cyc < 1010) begin
            bus.csi_lp_idle_i = (((cyc - 11) % 16) != 15);
            step(1);
        end
        chk("s4a_c1010", outs(), 6'b011100);
        step(1);
        chk("s4a_c1011_timeout", outs(), 6'b001101);

        // 4b: two short runs, then a run of 16 qualifies on its 16th sample
        do_reset("s4b");
        goto_cyc(10);
        bus.pwdn_req_i = 1'b1;
        step(1);
        bus.pwdn_req_i = 1'b0;
        while (cyc < 43) begin
            bus.csi_lp_idle_i = (((cyc - 11) % 16) != 15);
            step(1);
        end
        bus.csi_lp_idle_i = 1'b1;
        goto_cyc(58);
        chk("s4b_c58", outs(), 6'b011100);
        step(1);
        chk("s4b_c59_idle_rst", outs(), 6'b001100);

        // 4c: idle qualifies on the timeout edge -> idle wins; later idle drop ignored
        do_reset("s4c");
        goto_cyc(10);
        bus.pwdn_req_i = 1'b1;
        step(1);
        bus.pwdn_req_i = 1'b0;
        goto_cyc(995);
        bus.csi_lp_idle_i = 1'b1;
        goto_cyc(1010);
        chk("s4c_c1010", outs(), 6'b011100);
        step(1);
        chk("s4c_c1011_idle_wins", outs(), 6'b001100);
        bus.csi_lp_idle_i = 1'b0;
        goto_cyc(1021);
        chk("s4c_c1021_pwr_off", outs(), 6'b000100);
        goto_cyc(1121);
        chk("s4c_c1121_done", outs(), 6'b000010);

        // 5: reset during PWR_OFF, then a full restart
        do_reset("s5");
        goto_cyc(10);
        bus.pwdn_req_i = 1'b1;
        step(1);
        bus.pwdn_req_i = 1'b0;
        goto_cyc(20);
        bus.csi_lp_idle_i = 1'b1;
        goto_cyc(60);
        chk("s5_c60_in_pwr_off", outs(), 6'b000100);
        do_reset("s5_mid");
        run_nominal("s5_restart", 1'b0);

        // 6: request held throughout, re-asserted during RST
        do_reset("s6");
        run_nominal("s6", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
